// File: rtl/lru_update_unit.sv
// Tree pseudo-LRU replacement controller: per-set PLRU word, victim selection on miss,
// line-fill handshake and one-cycle completion pulse.
module lru_update_unit #(
  parameter int unsigned indexBits = 14,
  parameter int unsigned ways      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    accessValid,
  output logic                    accessReady,
  input  logic [indexBits-1:0]    index,
  input  logic                    hit,
  input  logic [ways-1:0]         hitWay,
  input  logic [ways-1:0]         valid,
  output logic                    fillReq,
  output logic [$clog2(ways)-1:0] fillWay,
  output logic [indexBits-1:0]    fillIndex,
  input  logic                    fillAck,
  output logic                    done,
  output logic [$clog2(ways)-1:0] doneWay,
  output logic                    doneHit
);

  localparam int unsigned WAY_BITS  = $clog2(ways);
  localparam int unsigned TREE_BITS = ways - 1;
  localparam int unsigned SETS      = 32'd1 << indexBits;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] READ      = 2'd1;
  localparam logic [1:0] FILL_WAIT = 2'd2;
  localparam logic [1:0] FINISH    = 2'd3;

  logic [1:0]           state;
  logic [1:0]           state_nx;
  logic [indexBits-1:0] idx_q;
  logic                 hit_q;
  logic [ways-1:0]      hit_way_q;
  logic [ways-1:0]      valid_q;
  logic [SETS-1:0]      set_init;
  logic [TREE_BITS-1:0] tree_mem [SETS];

  logic                 accept;
  logic                 hit_eff;
  logic [WAY_BITS-1:0]  hit_enc;
  logic [TREE_BITS-1:0] tree_rd;
  logic [TREE_BITS-1:0] tree_wd;
  logic [WAY_BITS-1:0]  miss_victim;
  logic                 tree_we;
  logic [WAY_BITS-1:0]  tree_way;

  // Index of the lowest set bit (0 when none is set).
  function automatic logic [WAY_BITS-1:0] lowest_one(input logic [ways-1:0] v);
    logic [WAY_BITS-1:0] r;
    r = '0;
    for (int i = int'(ways) - 1; i >= 0; i--) begin
      if (v[WAY_BITS'(i)]) r = WAY_BITS'(i);
    end
    return r;
  endfunction

  // Walk from the root: a 0 node sends the walk to the lower half, a 1 to the upper half.
  function automatic logic [WAY_BITS-1:0] tree_victim(input logic [TREE_BITS-1:0] t);
    logic [WAY_BITS-1:0] r;
    logic                b;
    int                  node;
    r    = '0;
    node = 0;
    for (int l = 0; l < int'(WAY_BITS); l++) begin
      b    = t[WAY_BITS'(node)];
      r    = (r << 1) | WAY_BITS'(b);
      node = 2 * node + 1 + int'(b);
    end
    return r;
  endfunction

  // Point every node on the path of way w away from w.
  function automatic logic [TREE_BITS-1:0] tree_touch(input logic [TREE_BITS-1:0] t,
                                                      input logic [WAY_BITS-1:0]  w);
    logic [TREE_BITS-1:0] r;
    logic [WAY_BITS-1:0]  ws;
    logic                 b;
    int                   node;
    r    = t;
    ws   = w;
    node = 0;
    for (int l = 0; l < int'(WAY_BITS); l++) begin
      b                  = ws[WAY_BITS-1];
      ws                 = ws << 1;
      r[WAY_BITS'(node)] = ~b;
      node               = 2 * node + 1 + int'(b);
    end
    return r;
  endfunction

  assign accept = accessValid && accessReady;

  // Sets never written since reset read back as an all-zero tree.
  always_comb begin
    hit_eff     = hit_q && (|hit_way_q);
    hit_enc     = lowest_one(hit_way_q);
    tree_rd     = set_init[idx_q] ? tree_mem[idx_q] : '0;
    miss_victim = (&valid_q) ? tree_victim(tree_rd) : lowest_one(~valid_q);
    tree_we     = 1'b0;
    tree_way    = '0;
    if (state == READ && hit_eff) begin
      tree_we  = 1'b1;
      tree_way = hit_enc;
    end else if (state == FILL_WAIT && fillAck) begin
      tree_we  = 1'b1;
      tree_way = fillWay;
    end
    tree_wd = tree_touch(tree_rd, tree_way);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (accept) state_nx = READ;
      READ:      state_nx = hit_eff ? FINISH : FILL_WAIT;
      FILL_WAIT: if (fillAck) state_nx = FINISH;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Registered outputs follow the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accessReady <= 1'b1;
      fillReq     <= 1'b0;
      done        <= 1'b0;
      fillWay     <= '0;
      fillIndex   <= '0;
      doneWay     <= '0;
      doneHit     <= 1'b0;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      hit_way_q   <= '0;
      valid_q     <= '0;
      set_init    <= '0;
    end else begin
      accessReady <= (state_nx == IDLE);
      fillReq     <= (state_nx == FILL_WAIT);
      done        <= (state_nx == FINISH);
      if (accept) begin
        idx_q     <= index;
        hit_q     <= hit;
        hit_way_q <= hitWay;
        valid_q   <= valid;
      end
      if (state == READ && !hit_eff) begin
        fillWay   <= miss_victim;
        fillIndex <= idx_q;
      end
      if (state == READ && hit_eff) begin
        doneWay <= hit_enc;
        doneHit <= 1'b1;
      end
      if (state == FILL_WAIT && fillAck) begin
        doneWay <= fillWay;
        doneHit <= 1'b0;
      end
      if (tree_we) set_init[idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tree_we) tree_mem[idx_q] <= tree_wd;
  end

endmodule

// File: tb/tb_lru_update_unit.sv
// Directed bench for lru_update_unit: table of accesses with hand-computed victims,
// plus sequences for held accessValid, stray fillAck and reset during a fill.
module tb_lru_update_unit;

  logic        clk;
  logic        reset;
  logic        accessValid;
  logic        accessReady;
  logic [13:0] index;
  logic        hit;
  logic [7:0]  hitWay;
  logic [7:0]  valid;
  logic        fillReq;
  logic [2:0]  fillWay;
  logic [13:0] fillIndex;
  logic        fillAck;
  logic        done;
  logic [2:0]  doneWay;
  logic        doneHit;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [13:0] idx;
    logic        hit;
    logic [7:0]  hit_way;
    logic [7:0]  valid;
    int          ack_delay;
    logic        exp_hit;
    logic [2:0]  exp_way;
  } vec_t;

  vec_t vecs[13];

  lru_update_unit #(.indexBits(14), .ways(8)) dut (
    .clk(clk), .reset(reset),
    .accessValid(accessValid), .accessReady(accessReady),
    .index(index), .hit(hit), .hitWay(hitWay), .valid(valid),
    .fillReq(fillReq), .fillWay(fillWay), .fillIndex(fillIndex), .fillAck(fillAck),
    .done(done), .doneWay(doneWay), .doneHit(doneHit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input string name,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s.%s got=%0h expected=%0h t=%0t", tag, name, got, exp, $time);
    else
      passes++;
  endtask

  // Issues one access from IDLE and follows it to completion.
  task automatic run_access(input vec_t v, input string tag);
    logic hold_ok;
    check(tag, "ready_before", 32'(accessReady), 32'd1);
    accessValid = 1'b1; index = v.idx; hit = v.hit; hitWay = v.hit_way; valid = v.valid;
    step();
    accessValid = 1'b0; index = ~v.idx; hit = ~v.hit; hitWay = ~v.hit_way; valid = ~v.valid;
    check(tag, "busy_ready", 32'(accessReady), 32'd0);
    check(tag, "busy_done", 32'(done), 32'd0);
    step();
    if (v.exp_hit) begin
      check(tag, "hit_done", 32'(done), 32'd1);
      check(tag, "hit_doneHit", 32'(doneHit), 32'd1);
      check(tag, "hit_doneWay", 32'(doneWay), 32'(v.exp_way));
      check(tag, "hit_fillReq", 32'(fillReq), 32'd0);
    end else begin
      check(tag, "fillReq", 32'(fillReq), 32'd1);
      check(tag, "fillWay", 32'(fillWay), 32'(v.exp_way));
      check(tag, "fillIndex", 32'(fillIndex), 32'(v.idx));
      check(tag, "miss_done", 32'(done), 32'd0);
      hold_ok = 1'b1;
      repeat (v.ack_delay - 1) begin
        step();
        if (!(fillReq && fillWay == v.exp_way && fillIndex == v.idx && !done && !accessReady))
          hold_ok = 1'b0;
      end
      check(tag, "fill_hold", 32'(hold_ok), 32'd1);
      fillAck = 1'b1;
      step();
      fillAck = 1'b0;
      check(tag, "fill_done", 32'(done), 32'd1);
      check(tag, "fill_doneHit", 32'(doneHit), 32'd0);
      check(tag, "fill_doneWay", 32'(doneWay), 32'(v.exp_way));
      check(tag, "fill_reqdrop", 32'(fillReq), 32'd0);
    end
    step();
    check(tag, "after_done", 32'(done), 32'd0);
    check(tag, "after_ready", 32'(accessReady), 32'd1);
  endtask

  initial begin
    logic [5:0] exp_rdy;
    logic [5:0] exp_dn;
    vec_t       v;

    // idx, hit, hitWay, valid, ack delay, expect hit, expected way
    vecs[0]  = '{14'd5,  1'b0, 8'h00, 8'hFF, 3, 1'b0, 3'd0};
    vecs[1]  = '{14'd5,  1'b0, 8'h00, 8'hFF, 3, 1'b0, 3'd4};
    vecs[2]  = '{14'd5,  1'b0, 8'h00, 8'hFF, 3, 1'b0, 3'd2};
    vecs[3]  = '{14'd5,  1'b0, 8'h00, 8'hFF, 3, 1'b0, 3'd6};
    vecs[4]  = '{14'd5,  1'b0, 8'h00, 8'hF7, 2, 1'b0, 3'd3};
    vecs[5]  = '{14'd9,  1'b1, 8'h01, 8'hFF, 1, 1'b1, 3'd0};
    vecs[6]  = '{14'd9,  1'b0, 8'h00, 8'hFF, 1, 1'b0, 3'd4};
    vecs[7]  = '{14'd20, 1'b1, 8'h00, 8'hFF, 2, 1'b0, 3'd0};
    vecs[8]  = '{14'd21, 1'b1, 8'h60, 8'hFF, 1, 1'b1, 3'd5};
    vecs[9]  = '{14'd21, 1'b0, 8'h00, 8'hFF, 1, 1'b0, 3'd0};
    vecs[10] = '{14'd22, 1'b0, 8'h00, 8'h7F, 4, 1'b0, 3'd7};
    vecs[11] = '{14'd22, 1'b0, 8'h00, 8'h00, 1, 1'b0, 3'd0};
    vecs[12] = '{14'd23, 1'b0, 8'h04, 8'hFF, 1, 1'b0, 3'd0};

    reset = 1'b1; accessValid = 1'b0; index = '0; hit = 1'b0;
    hitWay = '0; valid = '0; fillAck = 1'b0;
    step(); step();
    reset = 1'b0;
    check("reset", "accessReady", 32'(accessReady), 32'd1);
    check("reset", "fillReq", 32'(fillReq), 32'd0);
    check("reset", "done", 32'(done), 32'd0);
    check("reset", "doneHit", 32'(doneHit), 32'd0);
    check("reset", "doneWay", 32'(doneWay), 32'd0);
    check("reset", "fillWay", 32'(fillWay), 32'd0);
    check("reset", "fillIndex", 32'(fillIndex), 32'd0);

    for (int i = 0; i < 13; i++) run_access(vecs[i], $sformatf("vec%0d", i));

    // accessValid held high across two hits: one acceptance per IDLE visit
    exp_rdy = 6'b100100;
    exp_dn  = 6'b010010;
    accessValid = 1'b1; index = 14'd30; hit = 1'b1; hitWay = 8'h04; valid = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("hold_hit%0d", k), "accessReady", 32'(accessReady), 32'(exp_rdy[k]));
      check($sformatf("hold_hit%0d", k), "done", 32'(done), 32'(exp_dn[k]));
      if (exp_dn[k]) check($sformatf("hold_hit%0d", k), "doneWay", 32'(doneWay), 32'd2);
    end
    accessValid = 1'b0;
    step();
    check("hold_hit_end", "accessReady", 32'(accessReady), 32'd1);

    // accessValid held through a fill, index changing underneath
    accessValid = 1'b1; index = 14'd40; hit = 1'b0; hitWay = '0; valid = 8'hFF;
    step();
    index = 14'd41;
    step();
    check("hold_miss", "fillReq", 32'(fillReq), 32'd1);
    check("hold_miss", "fillWay", 32'(fillWay), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("hold_miss", "ready_wait", 32'(accessReady), 32'd0);
      check("hold_miss", "fillIndex", 32'(fillIndex), 32'd40);
    end
    fillAck = 1'b1;
    step();
    fillAck = 1'b0; accessValid = 1'b0;
    check("hold_miss", "done", 32'(done), 32'd1);
    check("hold_miss", "ready_finish", 32'(accessReady), 32'd0);
    step();
    step();
    check("hold_miss", "ready_end", 32'(accessReady), 32'd1);
    check("hold_miss", "no_second_done", 32'(done), 32'd0);

    // stray fillAck in IDLE has no effect
    fillAck = 1'b1;
    step(); step();
    fillAck = 1'b0;
    check("stray_ack", "done", 32'(done), 32'd0);
    check("stray_ack", "fillReq", 32'(fillReq), 32'd0);
    check("stray_ack", "accessReady", 32'(accessReady), 32'd1);

    // reset in the middle of a fill
    v = '{14'd50, 1'b1, 8'h01, 8'hFF, 1, 1'b1, 3'd0};
    run_access(v, "pre_rst_hit");
    accessValid = 1'b1; index = 14'd50; hit = 1'b0; hitWay = '0; valid = 8'hFF;
    step();
    accessValid = 1'b0;
    step();
    check("rst_fill", "fillReq", 32'(fillReq), 32'd1);
    check("rst_fill", "fillWay", 32'(fillWay), 32'd4);
    #2 reset = 1'b1;
    #1;
    check("rst_fill", "fillReq_async", 32'(fillReq), 32'd0);
    check("rst_fill", "done_async", 32'(done), 32'd0);
    step();
    reset = 1'b0; fillAck = 1'b1;
    check("rst_fill", "done_in_reset", 32'(done), 32'd0);
    step();
    fillAck = 1'b0;
    check("rst_fill", "done_after", 32'(done), 32'd0);
    check("rst_fill", "accessReady", 32'(accessReady), 32'd1);
    check("rst_fill", "fillWay_cleared", 32'(fillWay), 32'd0);
    check("rst_fill", "fillIndex_cleared", 32'(fillIndex), 32'd0);
    v = '{14'd50, 1'b0, 8'h00, 8'hFF, 2, 1'b0, 3'd0};
    run_access(v, "post_rst_miss");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
